// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- MIPS general-purpose register file. This is the receiving end
// of the writeback interface.
//
// The writeback stage supplies the RegWrite bit, the destination register
// number and the selected write data. Decode reads operands through two
// combinational ports (rs, rt). A value that is being written back in the
// current cycle is forwarded onto those ports. A debug port shows committed
// state only, and wr_count counts every write that actually retired.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears registers and counter)
//   regwrite   write enable from MEM/WB
//   write_reg  destination register number
//   writedata  data from the writeback mux
//   rs, rt     decode read addresses
//   readdat1   contents of rs, with same-cycle bypass
//   readdat2   contents of rt, with same-cycle bypass
//   dbg_addr   debug read address
//   dbg_data   committed contents of dbg_addr (no bypass)
//   wr_count   committed, non-discarded writes since reset (wraps at 2^32)
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int NREGS    = 32,
  parameter int DW       = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwrite,
  input  logic [4:0]    write_reg,
  input  logic [DW-1:0] writedata,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] readdat1,
  output logic [DW-1:0] readdat2,
  output logic [DW-1:0] dbg_data,
  output logic [31:0]   wr_count
);

  localparam int AW = $clog2(NREGS);

  logic [DW-1:0] mem_reg [NREGS];
  logic [31:0]   wr_count_reg;
  logic          wr_en;
  logic          bypass_en;

  // A write to r0 is dropped entirely when r0 is hardwired. Such a write
  // neither stores data nor counts as retired.
  assign wr_en     = regwrite && !((ZERO_REG != 0) && (write_reg == 5'd0));
  // Reset has priority over a write in the same cycle, so it also disables
  // forwarding. During reset the ports show what is actually stored.
  assign bypass_en = regwrite && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_reg[i] <= '0;
      end
      wr_count_reg <= '0;
    end else if (wr_en) begin
      mem_reg[write_reg[AW-1:0]] <= writedata;
      wr_count_reg               <= wr_count_reg + 32'd1;
    end
  end

  // The zero check comes first so that a hardwired r0 never forwards data.
  // After that, a matching in-flight write overrides the stored value.
  function automatic logic [DW-1:0] port_read(input logic [4:0] addr,
                                              input logic       use_bypass);
    if ((ZERO_REG != 0) && (addr == 5'd0))
      return '0;
    else if (use_bypass && bypass_en && (addr == write_reg))
      return writedata;
    else
      return mem_reg[addr[AW-1:0]];
  endfunction

  assign readdat1 = port_read(rs, 1'b1);
  assign readdat2 = port_read(rt, 1'b1);
  assign dbg_data = port_read(dbg_addr, 1'b0);
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile -- self-checking bench for wb_regfile.
//
// A reference model (an array of registers plus a write counter) is updated
// as stimulus is driven. Each expected value is pushed onto exp_q when the
// stimulus is applied. It is popped and compared when the DUT output is
// sampled, 1 ns after inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] writedata;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  dbg_addr;
  logic [31:0] readdat1;
  logic [31:0] readdat2;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [32];
  logic [31:0] cnt_model;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  wb_regfile #(.NREGS(32), .DW(32), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .regwrite  (regwrite),
    .write_reg (write_reg),
    .writedata (writedata),
    .rs        (rs),
    .rt        (rt),
    .dbg_addr  (dbg_addr),
    .readdat1  (readdat1),
    .readdat2  (readdat2),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt_model = 32'h0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      model[a]  = d;
      cnt_model = cnt_model + 32'd1;
    end
  endtask

  // The task is entered just after a falling edge and returns just after the
  // next falling edge, with regwrite released.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    regwrite  = 1'b1;
    write_reg = a;
    writedata = d;
    @(posedge clk);
    model_write(a, d);
    @(negedge clk);
    regwrite = 1'b0;
    $display("write r%0d = %h  model count=%0d", a, d, cnt_model);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dbg_addr = 5'd5;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL reset_init_count got=%h exp=%h", wr_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL reset_init_dbg got=%h exp=%h", dbg_data, exp_v); end

    do_write(5'd5, 32'h12345678);
    do_write(5'd7, 32'h00000077);

    // Reset cycle with a competing write to r7. Bypass must be suppressed.
    rst       = 1'b1;
    regwrite  = 1'b1;
    write_reg = 5'd7;
    writedata = 32'hBAD0BAD0;
    rs        = 5'd7;
    rt        = 5'd5;
    #1;
    exp_q.push_back(model[7]);
    exp_q.push_back(model[5]);
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL reset_no_bypass_rd1 got=%h exp=%h", readdat1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (readdat2 !== exp_v) begin errors++; $display("FAIL reset_hold_rd2 got=%h exp=%h", readdat2, exp_v); end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst      = 1'b0;
    regwrite = 1'b0;
    rs       = 5'd5;
    rt       = 5'd7;
    dbg_addr = 5'd5;
    #1;
    exp_q.push_back(model[5]);
    exp_q.push_back(model[5]);
    exp_q.push_back(model[7]);
    exp_q.push_back(cnt_model);
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL reset_dbg_r5 got=%h exp=%h", dbg_data, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL reset_rd1_r5 got=%h exp=%h", readdat1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (readdat2 !== exp_v) begin errors++; $display("FAIL reset_rd2_r7 got=%h exp=%h", readdat2, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL reset_count got=%h exp=%h", wr_count, exp_v); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'hDEADBEEF);
    rs = 5'd3;
    rt = 5'd4;
    #1;
    exp_q.push_back(model[3]);
    exp_q.push_back(model[4]);
    exp_q.push_back(cnt_model);
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL basic_rd1 got=%h exp=%h", readdat1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (readdat2 !== exp_v) begin errors++; $display("FAIL basic_rd2 got=%h exp=%h", readdat2, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL basic_count got=%h exp=%h", wr_count, exp_v); end
    $display("test_basic done");
  endtask

  task automatic test_bypass();
    regwrite  = 1'b1;
    write_reg = 5'd9;
    writedata = 32'hA5A5A5A5;
    rs        = 5'd9;
    rt        = 5'd9;
    dbg_addr  = 5'd9;
    #1;
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(model[9]);
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL bypass_rd1 got=%h exp=%h", readdat1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (readdat2 !== exp_v) begin errors++; $display("FAIL bypass_rd2 got=%h exp=%h", readdat2, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL bypass_dbg_old got=%h exp=%h", dbg_data, exp_v); end
    @(posedge clk);
    model_write(5'd9, 32'hA5A5A5A5);
    @(negedge clk);
    regwrite = 1'b0;
    #1;
    exp_q.push_back(model[9]);
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL bypass_dbg_new got=%h exp=%h", dbg_data, exp_v); end
    $display("test_bypass done");
  endtask

  task automatic test_zero();
    regwrite  = 1'b1;
    write_reg = 5'd0;
    writedata = 32'hFFFFFFFF;
    rs        = 5'd0;
    dbg_addr  = 5'd0;
    #1;
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL zero_no_bypass got=%h exp=%h", readdat1, exp_v); end
    @(posedge clk);
    model_write(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    regwrite = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(cnt_model);
    exp_v = exp_q.pop_front(); checks++;
    if (readdat1 !== exp_v) begin errors++; $display("FAIL zero_rd1 got=%h exp=%h", readdat1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL zero_dbg got=%h exp=%h", dbg_data, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL zero_count got=%h exp=%h", wr_count, exp_v); end
    $display("test_zero done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    c0 = cnt_model;
    do_write(5'd31, 32'h1);
    do_write(5'd31, 32'h2);
    dbg_addr = 5'd31;
    #1;
    exp_q.push_back(32'h2);
    exp_q.push_back(c0 + 32'd2);
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL b2b_r31 got=%h exp=%h", dbg_data, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL b2b_count got=%h exp=%h", wr_count, exp_v); end
    $display("test_back_to_back done");
  endtask

  task automatic test_sweep();
    for (int n = 1; n < 32; n++) do_write(5'(n), 32'(n) * 32'h01010101);
    for (int n = 0; n < 32; n++) begin
      dbg_addr = 5'(n);
      rs       = 5'(31 - n);
      #1;
      exp_q.push_back(32'(n) * 32'h01010101);
      exp_q.push_back(model[31 - n]);
      exp_v = exp_q.pop_front(); checks++;
      if (dbg_data !== exp_v) begin errors++; $display("FAIL sweep_dbg r%0d got=%h exp=%h", n, dbg_data, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (readdat1 !== exp_v) begin errors++; $display("FAIL sweep_rd1 r%0d got=%h exp=%h", 31 - n, readdat1, exp_v); end
      $display("sweep r%0d dbg=%h rd1(r%0d)=%h", n, dbg_data, 31 - n, readdat1);
    end
    exp_q.push_back(cnt_model);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL sweep_count got=%h exp=%h", wr_count, exp_v); end
    $display("test_sweep done");
  endtask

  task automatic test_wrap();
    regwrite = 1'b0;
    force dut.wr_count_reg = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_reg;
    cnt_model = 32'hFFFFFFFF;
    do_write(5'd12, 32'h0000000C);
    #1;
    exp_q.push_back(cnt_model);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL wrap_count got=%h exp=%h", wr_count, exp_v); end
    dbg_addr = 5'd12;
    #1;
    exp_q.push_back(model[12]);
    exp_v = exp_q.pop_front(); checks++;
    if (dbg_data !== exp_v) begin errors++; $display("FAIL wrap_r12 got=%h exp=%h", dbg_data, exp_v); end
    $display("test_wrap done");
  endtask

  initial begin
    rst       = 1'b1;
    regwrite  = 1'b0;
    write_reg = 5'd0;
    writedata = 32'h0;
    rs        = 5'd0;
    rt        = 5'd0;
    dbg_addr  = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_back_to_back();
    test_sweep();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
